// File: rtl/i2c_reg_target.sv
// i2c_reg_target
//   I2C target (responder) bridging SDA/SCL pads to a byte-wide register port.
//   Write frame: START, ADDR+W, REG, DATA..., STOP
//   Read frame : START, ADDR+W, REG, rSTART, ADDR+R, DATA..., STOP
//
// Build option: define I2C_AUTOINC_EN to advance reg_addr (mod 256) after
// every data byte, read or write. Without it, burst bytes hit the register
// selected by the REG byte.
//
// Parameters
//   DEV_ADDR     7-bit target address matched after START
//   SYNC_STAGES  flops in each SCL/SDA input synchronizer (>= 2)
// Ports
//   clk        system clock, at least 8x the SCL rate
//   rst        synchronous reset, active-high
//   scl_in     SCL pad input (asynchronous)
//   sda_in     SDA pad input (asynchronous)
//   sda_oe     1 = pull SDA low (pad output data tied to 0)
//   reg_addr   register pointer
//   reg_wdata  write data, valid while reg_we = 1
//   reg_we     one-cycle write strobe
//   reg_re     one-cycle read strobe; reg_rdata is captured in that cycle
//   reg_rdata  read data for reg_addr (combinational from register file)
//   busy       1 from START to STOP
module i2c_reg_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h5A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

`ifdef I2C_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK,
        WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers plus one history flop for edge detection.
    // Reset to 1 (idle bus level) so leaving reset never fakes an edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_d, sda_d;
    logic                   scl_s, sda_s;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // NOTE: clocked state always uses non-blocking (<=) assignments so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  =  scl_s & ~scl_d;
    assign scl_fall  = ~scl_s &  scl_d;
    // SDA may only move while SCL is high for START/STOP.
    assign start_det =  scl_s & scl_d &  sda_d & ~sda_s;
    assign stop_det  =  scl_s & scl_d & ~sda_d &  sda_s;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    state_t     state, state_n;
    logic [3:0] bit_cnt, bit_cnt_n;     // SCL rises seen in the current byte
    logic [7:0] shift, shift_n;
    logic       sda_oe_q, sda_oe_n;
    logic [7:0] reg_addr_q, reg_addr_n;
    logic [7:0] reg_wdata_q, reg_wdata_n;
    logic       reg_we_q, reg_we_n;
    logic       rd_load;                // fetch next read byte this cycle

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            sda_oe_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            shift       <= shift_n;
            sda_oe_q    <= sda_oe_n;
            reg_addr_q  <= reg_addr_n;
            reg_wdata_q <= reg_wdata_n;
            reg_we_q    <= reg_we_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        sda_oe_n    = sda_oe_q;
        reg_addr_n  = reg_addr_q;
        reg_wdata_n = reg_wdata_q;
        reg_we_n    = 1'b0;
        rd_load     = 1'b0;

        // Write pointer advances the cycle after the strobe, so the
        // register file sees the pre-increment address with reg_we.
        if (AUTOINC && reg_we_q) reg_addr_n = reg_addr_q + 8'd1;

        if (start_det) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
        end else if (stop_det) begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
        end else begin
            unique case (state)
                ADDR, REG, WDATA: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shift_n   = {shift[6:0], sda_s};
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (state == WDATA && bit_cnt == 4'd7) begin
                            reg_wdata_n = {shift[6:0], sda_s};
                            reg_we_n    = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        // Byte complete: this fall opens the 9th (ACK) clock.
                        bit_cnt_n = '0;
                        if (state == ADDR) begin
                            if (shift[7:1] == DEV_ADDR) begin
                                state_n  = ADDR_ACK;
                                sda_oe_n = 1'b1;
                            end else begin
                                state_n  = IGNORE;
                            end
                        end else if (state == REG) begin
                            reg_addr_n = shift;
                            state_n    = REG_ACK;
                            sda_oe_n   = 1'b1;
                        end else begin
                            state_n    = WDATA_ACK;
                            sda_oe_n   = 1'b1;
                        end
                    end
                end
                ADDR_ACK: begin
                    // First fall after entry ends the ACK clock.
                    if (scl_fall) begin
                        sda_oe_n = 1'b0;
                        if (shift[0]) rd_load = 1'b1;
                        else          state_n = REG;
                    end
                end
                REG_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_n = 1'b0;
                        state_n  = WDATA;
                    end
                end
                RDATA: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = '0;
                        state_n   = RDATA_ACK;
                        if (AUTOINC) reg_addr_n = reg_addr_q + 8'd1;
                    end else if (scl_fall && bit_cnt != 4'd0) begin
                        shift_n  = {shift[6:0], 1'b0};
                        sda_oe_n = ~shift[6];
                    end
                end
                RDATA_ACK: begin
                    // bit_cnt != 0 records that the master ACKed on the rise.
                    if (scl_rise) begin
                        if (sda_s) state_n   = IGNORE;
                        else       bit_cnt_n = 4'd1;
                    end else if (scl_fall && bit_cnt != 4'd0) begin
                        rd_load = 1'b1;
                    end
                end
                default: ;  // IDLE, IGNORE: wait for START/STOP
            endcase

            // Read fetch: capture the byte and put its MSB on the bus at once.
            if (rd_load) begin
                state_n   = RDATA;
                shift_n   = reg_rdata;
                sda_oe_n  = ~reg_rdata[7];
                bit_cnt_n = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        sda_oe    = sda_oe_q;
        reg_addr  = reg_addr_q;
        reg_wdata = reg_wdata_q;
        reg_we    = reg_we_q;
        // Combinational so reg_rdata is captured in the same cycle as the strobe.
        reg_re    = rd_load & ~rst;
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Testbench for i2c_reg_target: a bit-banged I2C master drives the bus, a
// behavioural register-file model supplies read data, and expected strobes
// and bytes are derived from the transaction being issued.
module tb_i2c_reg_target;

    localparam logic [6:0] DEV = 7'h5A;
`ifdef I2C_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m, sda_m;
    logic       sda_line;
    logic       sda_oe, reg_we, reg_re, busy;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;

    // Open-drain bus: either side can pull low.
    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    logic [7:0] rf [256];
    assign reg_rdata = rf[reg_addr];

    i2c_reg_target #(.DEV_ADDR(DEV), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_m),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int both_cnt = 0;
    int oe_cnt   = 0;
    logic [15:0] we_q [$];
    logic [7:0]  re_q [$];
    logic [7:0]  wbuf [8];

    // Strobe monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (reg_we) we_q.push_back({reg_addr, reg_wdata});
        if (reg_re) re_q.push_back(reg_addr);
        if (reg_we && reg_re) both_cnt++;
        if (sda_oe) oe_cnt++;
    end

    initial begin
        #800us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Register targeted by data byte i of a burst starting at ra.
    function automatic logic [7:0] exp_addr(input logic [7:0] ra, input int i);
        return AUTOINC ? ra + 8'(i) : ra;
    endfunction

    // ---------------- bus master primitives (quarter period 50 ns) -------
    task automatic send_bit(input logic b, output logic s);
        sda_m = b;  #50;
        scl_m = 1;  #50;
        s = sda_line; #50;
        scl_m = 0;  #50;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(d[i], s);
        send_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            d[i] = s;
        end
        send_bit(nack, s);
    endtask

    task automatic i2c_start();
        sda_m = 1; #50;
        scl_m = 1; #50;
        sda_m = 0; #50;
        scl_m = 0; #50;
    endtask

    task automatic i2c_stop();
        sda_m = 0; #50;
        scl_m = 1; #50;
        sda_m = 1; #50;
    endtask

    // ---------------- transactions ---------------------------------------
    task automatic write_txn(input string name, input logic [6:0] dev,
                             input logic [7:0] ra, input int n);
        logic ack, exp_ack;
        int   wb, rb, ob, exp_we;
        exp_ack = (dev == DEV) ? 1'b0 : 1'b1;
        exp_we  = (dev == DEV) ? n : 0;
        wb = we_q.size(); rb = re_q.size(); ob = oe_cnt;
        i2c_start();
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_after_start: got %b want 1", name, busy); end
        send_byte({dev, 1'b0}, ack);
        n_checks++;
        if (ack !== exp_ack) begin n_fail++; $display("FAIL %s addr_ack: got %b want %b", name, ack, exp_ack); end
        send_byte(ra, ack);
        n_checks++;
        if (ack !== exp_ack) begin n_fail++; $display("FAIL %s reg_ack: got %b want %b", name, ack, exp_ack); end
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i], ack);
            n_checks++;
            if (ack !== exp_ack) begin n_fail++; $display("FAIL %s data_ack[%0d]: got %b want %b", name, i, ack, exp_ack); end
        end
        i2c_stop();
        #50;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_after_stop: got %b want 0", name, busy); end
        n_checks++;
        if (we_q.size() - wb != exp_we) begin
            n_fail++; $display("FAIL %s we_count: got %0d want %0d", name, we_q.size() - wb, exp_we);
        end else begin
            for (int i = 0; i < exp_we; i++) begin
                n_checks++;
                if (we_q[wb + i] !== {exp_addr(ra, i), wbuf[i]}) begin
                    n_fail++;
                    $display("FAIL %s write[%0d]: got addr/data %h want %h", name, i, we_q[wb + i], {exp_addr(ra, i), wbuf[i]});
                end
            end
        end
        n_checks++;
        if (re_q.size() != rb) begin n_fail++; $display("FAIL %s re_count: got %0d want %0d", name, re_q.size(), rb); end
        if (dev != DEV) begin
            n_checks++;
            if (oe_cnt != ob) begin n_fail++; $display("FAIL %s sda_oe_quiet: got %0d cycles want 0", name, oe_cnt - ob); end
        end
    endtask

    task automatic read_txn(input string name, input logic [7:0] ra, input int n);
        logic       ack;
        logic [7:0] d;
        int         wb, rb;
        wb = we_q.size(); rb = re_q.size();
        i2c_start();
        send_byte({DEV, 1'b0}, ack);
        n_checks++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL %s addr_w_ack: got %b want 0", name, ack); end
        send_byte(ra, ack);
        n_checks++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL %s reg_ack: got %b want 0", name, ack); end
        i2c_start();
        send_byte({DEV, 1'b1}, ack);
        n_checks++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL %s addr_r_ack: got %b want 0", name, ack); end
        for (int i = 0; i < n; i++) begin
            recv_byte(i == n - 1, d);
            n_checks++;
            if (d !== rf[exp_addr(ra, i)]) begin
                n_fail++; $display("FAIL %s rdata[%0d]: got %h want %h", name, i, d, rf[exp_addr(ra, i)]);
            end
        end
        n_checks++;
        if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL %s released_after_nack: got %b want 0", name, sda_oe); end
        i2c_stop();
        #50;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_after_stop: got %b want 0", name, busy); end
        n_checks++;
        if (re_q.size() - rb != n) begin
            n_fail++; $display("FAIL %s re_count: got %0d want %0d", name, re_q.size() - rb, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                n_checks++;
                if (re_q[rb + i] !== exp_addr(ra, i)) begin
                    n_fail++; $display("FAIL %s re_addr[%0d]: got %h want %h", name, i, re_q[rb + i], exp_addr(ra, i));
                end
            end
        end
        n_checks++;
        if (we_q.size() != wb) begin n_fail++; $display("FAIL %s we_count: got %0d want 0", name, we_q.size() - wb); end
    endtask

    // ---------------- scenarios ------------------------------------------
    task automatic test_reset();
        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_values: got oe=%b addr=%h wdata=%h we=%b re=%b busy=%b want all 0",
                     sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write_single();
        wbuf[0] = 8'h20;
        write_txn("write_01_20", DEV, 8'h01, 1);
    endtask

    task automatic test_read_single();
        read_txn("read_0a", 8'h0A, 1);
    endtask

    task automatic test_addr_mismatch();
        write_txn("mismatch_5b", 7'h5B, 8'h07, 0);
    endtask

    task automatic test_burst_write();
        wbuf[0] = 8'h32; wbuf[1] = 8'h00;
        write_txn("burst_05", DEV, 8'h05, 2);
        wbuf[0] = 8'hAA; wbuf[1] = 8'hBB;
        write_txn("burst_ff_wrap", DEV, 8'hFF, 2);
    endtask

    task automatic test_burst_read();
        read_txn("burst_read_fe", 8'hFE, 3);
    endtask

    task automatic test_random();
        logic [7:0] ra;
        int         n;
        for (int it = 0; it < 8; it++) begin
            ra = 8'($urandom);
            n  = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                write_txn("rand_write", DEV, ra, n);
            end else begin
                read_txn("rand_read", ra, n);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic s, ack;
        int   wb;
        wb = we_q.size();
        i2c_start();
        send_byte({DEV, 1'b0}, ack);
        for (int i = 7; i >= 4; i--) send_bit(1'b0, s);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_reset busy_before: got %b want 1", busy); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy} !== 20'h0) begin
            n_fail++;
            $display("FAIL mid_reset values: got oe=%b addr=%h wdata=%h we=%b re=%b busy=%b want all 0",
                     sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy);
        end
        rst = 1'b0;
        #100;
        i2c_stop();
        #50;
        n_checks++;
        if (we_q.size() != wb) begin n_fail++; $display("FAIL mid_reset no_write: got %0d strobes want 0", we_q.size() - wb); end
        wbuf[0] = 8'h10;
        write_txn("post_reset_write", DEV, 8'h01, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rf[i] = 8'($urandom);
        rf[8'h0A] = 8'h01;
        test_reset();
        test_write_single();
        test_read_single();
        test_addr_mismatch();
        test_burst_write();
        test_burst_read();
        test_random();
        test_mid_reset();
        n_checks++;
        if (both_cnt != 0) begin n_fail++; $display("FAIL we_re_overlap: got %0d cycles want 0", both_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
